// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline stage register.
// Optional 2-entry skid mode; saturating stall counter.
module pipe_stage_reg #(
  parameter int WIDTH = 32,
  parameter bit SKID  = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
  logic [CNT_W-1:0] cnt_q;
  logic             in_fire;
  logic             out_fire;

  assign out_valid    = (state_q != EMPTY);
  assign out_data     = main_q;
  assign occupancy    = state_q;
  assign stall_cycles = cnt_q;

  // Skid mode keeps in_ready off the out_ready path.
  generate
    if (SKID) begin : g_skid
      assign in_ready = (state_q != FULL);
    end else begin : g_single
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush only drops validity; data regs keep known values.
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      if (out_valid && !out_ready && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule
